ex_issue_stage: RTL and testbench

// - ID/EX pipeline stage feeding alu_r: decodes RV32I OP/OP-IMM into alu_ctrl, selects and forwards operands, and registers them.
// - Single-entry register with valid/ready handshake, stall hold, flush-to-bubble and an illegal-op flag.
// - alu_a/alu_b/alu_ctrl drive alu_r directly. alu_r.result returns on alu_result for same-cycle forwarding.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_decode.sv | 97 +++++++++
 rtl/ex_issue_stage.sv | 156 +++++++++++++++
 tb/tb_ex_issue_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the issue stage and alu_r.
//   - alu_ctrl_e : 4-bit ALU operation encodings consumed by alu_r
//   - OPC_*      : RV32I major opcodes handled by the issue stage
//   - F3_* / F7_*: funct3 / funct7 field values used by the decoder
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_SRL = 4'b0011,
        ALU_OR  = 4'b0100,
        ALU_SLL = 4'b1000
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I OP / OP-IMM decoder for the issue stage.
//   opcode, funct3, funct7 : instruction fields
//   alu_ctrl               : ALU operation (ADD when illegal)
//   use_imm                : operand B comes from the immediate
//   shamt_mask             : operand B is a shift amount, keep only bits [4:0]
//   illegal                : combination not supported by alu_r
module alu_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl,
    output logic       use_imm,
    output logic       shamt_mask,
    output logic       illegal
);

    logic [3:0] ctrl_raw;

    always_comb begin
        ctrl_raw   = ALU_ADD;
        use_imm    = 1'b0;
        shamt_mask = 1'b0;
        illegal    = 1'b1;
        case (opcode)
            OPC_OP: begin
                // Register forms need a clean funct7 except SUB; this also
                // rejects the M-extension encodings (funct7 = 0000001).
                case (funct3)
                    F3_ADD: begin
                        if (funct7 == F7_ZERO) begin
                            ctrl_raw = ALU_ADD;
                            illegal  = 1'b0;
                        end else if (funct7 == F7_ALT) begin
                            ctrl_raw = ALU_SUB;
                            illegal  = 1'b0;
                        end
                    end
                    F3_AND: begin
                        ctrl_raw = ALU_AND;
                        illegal  = (funct7 != F7_ZERO);
                    end
                    F3_OR: begin
                        ctrl_raw = ALU_OR;
                        illegal  = (funct7 != F7_ZERO);
                    end
                    F3_SLL: begin
                        ctrl_raw   = ALU_SLL;
                        shamt_mask = 1'b1;
                        illegal    = (funct7 != F7_ZERO);
                    end
                    F3_SRL: begin
                        ctrl_raw   = ALU_SRL;
                        shamt_mask = 1'b1;
                        illegal    = (funct7 != F7_ZERO);
                    end
                    default: ;
                endcase
            end
            OPC_OPIMM: begin
                use_imm = 1'b1;
                // For ADDI/ANDI/ORI funct7 is immediate bits, so it is ignored.
                case (funct3)
                    F3_ADD: begin
                        ctrl_raw = ALU_ADD;
                        illegal  = 1'b0;
                    end
                    F3_AND: begin
                        ctrl_raw = ALU_AND;
                        illegal  = 1'b0;
                    end
                    F3_OR: begin
                        ctrl_raw = ALU_OR;
                        illegal  = 1'b0;
                    end
                    F3_SLL: begin
                        ctrl_raw   = ALU_SLL;
                        shamt_mask = 1'b1;
                        illegal    = (funct7 != F7_ZERO);
                    end
                    F3_SRL: begin
                        ctrl_raw   = ALU_SRL;
                        shamt_mask = 1'b1;
                        illegal    = (funct7 != F7_ZERO);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Illegal entries still flow down the pipe, so give them a harmless op.
    assign alu_ctrl = illegal ? ALU_ADD : ctrl_raw;

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX issue stage feeding alu_r: decodes OP/OP-IMM, forwards operands and
// registers them in a single-entry valid/ready pipeline register.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready           : handshake from ID
//   in_opcode/funct3/funct7     : instruction fields
//   in_rs1/rs2/rd_addr          : register indices
//   in_rs1/rs2_data, in_imm     : regfile reads and sign-extended immediate
//   alu_result                  : alu_r result for the entry held here
//   exm_*/wb_*                  : younger/older writeback info for forwarding
//   flush                       : drop held entry and any capture this cycle
//   out_valid/out_ready         : handshake to EX/MEM
//   alu_a/alu_b/alu_ctrl        : registered operands and op for alu_r
//   out_rd/out_wen/out_illegal  : destination, writeback enable, illegal flag
module ex_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              exm_wen,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_data,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_ctrl,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wen,
    output logic              out_illegal
);

    logic              out_valid_reg;
    logic [XLEN-1:0]   alu_a_reg;
    logic [XLEN-1:0]   alu_b_reg;
    logic [3:0]        alu_ctrl_reg;
    logic [REG_AW-1:0] out_rd_reg;
    logic              out_wen_reg;
    logic              out_illegal_reg;

    logic [3:0]        dec_ctrl;
    logic              dec_use_imm;
    logic              dec_shamt_mask;
    logic              dec_illegal;

    alu_decode u_decode (
        .opcode     (in_opcode),
        .funct3     (in_funct3),
        .funct7     (in_funct7),
        .alu_ctrl   (dec_ctrl),
        .use_imm    (dec_use_imm),
        .shamt_mask (dec_shamt_mask),
        .illegal    (dec_illegal)
    );

    logic fire_out;
    logic capture;
    logic retire_fwd;

    assign in_ready   = !out_valid_reg || out_ready;
    assign fire_out   = out_valid_reg && out_ready;
    assign capture    = in_valid && in_ready && !flush;
    // The held entry's result is only final if it actually leaves this cycle.
    assign retire_fwd = fire_out && out_wen_reg;

    // Index 0 = rs1, index 1 = rs2.
    logic [1:0][REG_AW-1:0] src_addr;
    logic [1:0][XLEN-1:0]   src_rf;
    logic [1:0][XLEN-1:0]   src_fwd;

    assign src_addr[0] = in_rs1_addr;
    assign src_addr[1] = in_rs2_addr;
    assign src_rf[0]   = in_rs1_data;
    assign src_rf[1]   = in_rs2_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [XLEN-1:0] fwd_next;
            // Youngest producer first; x0 is hard-wired zero and never forwarded.
            always_comb begin
                fwd_next = src_rf[gi];
                if (src_addr[gi] == '0) begin
                    fwd_next = '0;
                end else if (retire_fwd && (out_rd_reg == src_addr[gi])) begin
                    fwd_next = alu_result;
                end else if (exm_wen && (exm_rd == src_addr[gi])) begin
                    fwd_next = exm_data;
                end else if (wb_wen && (wb_rd == src_addr[gi])) begin
                    fwd_next = wb_data;
                end
            end
            assign src_fwd[gi] = fwd_next;
        end
    endgenerate

    logic [XLEN-1:0] b_sel;
    logic [XLEN-1:0] alu_b_next;
    logic            out_wen_next;

    assign b_sel        = dec_use_imm ? in_imm : src_fwd[1];
    assign alu_b_next   = dec_shamt_mask ? {{(XLEN-5){1'b0}}, b_sel[4:0]} : b_sel;
    assign out_wen_next = !dec_illegal && (in_rd_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg   <= 1'b0;
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
            alu_ctrl_reg    <= ALU_ADD;
            out_rd_reg      <= '0;
            out_wen_reg     <= 1'b0;
            out_illegal_reg <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
            out_wen_reg   <= 1'b0;
        end else if (capture) begin
            out_valid_reg   <= 1'b1;
            alu_a_reg       <= src_fwd[0];
            alu_b_reg       <= alu_b_next;
            alu_ctrl_reg    <= dec_ctrl;
            out_rd_reg      <= in_rd_addr;
            out_wen_reg     <= out_wen_next;
            out_illegal_reg <= dec_illegal;
        end else if (fire_out) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid   = out_valid_reg;
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_ctrl    = alu_ctrl_reg;
    assign out_rd      = out_rd_reg;
    assign out_wen     = out_wen_reg;
    assign out_illegal = out_illegal_reg;

endmodule

// File: tb/tb_ex_issue_stage.sv
module tb_ex_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic [31:0] alu_result;
    logic        exm_wen;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;

    ex_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_rs1_addr (in_rs1_addr),
        .in_rs2_addr (in_rs2_addr),
        .in_rd_addr  (in_rd_addr),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_imm      (in_imm),
        .alu_result  (alu_result),
        .exm_wen     (exm_wen),
        .exm_rd      (exm_rd),
        .exm_data    (exm_data),
        .wb_wen      (wb_wen),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .out_rd      (out_rd),
        .out_wen     (out_wen),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        in_valid    = 1'b1;
        in_opcode   = opc;
        in_funct3   = f3;
        in_funct7   = f7;
        in_rs1_addr = rs1;
        in_rs2_addr = rs2;
        in_rd_addr  = rd;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_imm      = imm;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c, input logic [4:0] rd, input logic w, input logic il);
        chk({tag, ".valid"},   {31'b0, out_valid},   {31'b0, v});
        chk({tag, ".a"},       alu_a,                a);
        chk({tag, ".b"},       alu_b,                b);
        chk({tag, ".ctrl"},    {28'b0, alu_ctrl},    {28'b0, c});
        chk({tag, ".rd"},      {27'b0, out_rd},      {27'b0, rd});
        chk({tag, ".wen"},     {31'b0, out_wen},     {31'b0, w});
        chk({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, il});
        $display("txn %s: valid=%0d a=%h b=%h ctrl=%b rd=%0d wen=%0d ill=%0d",
                 tag, out_valid, alu_a, alu_b, alu_ctrl, out_rd, out_wen, out_illegal);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        alu_result = '0; exm_wen = 1'b0; exm_rd = '0; exm_data = '0;
        wb_wen = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;

        repeat (2) step();
        chk_out("reset", 1'b0, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0);
        chk("reset.in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // ADD x3,x1,x2
        drive(OP, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        step();
        chk_out("add", 1'b1, 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0);

        // ADDI x1,x0,10 : x0 must read as zero whatever the regfile says
        drive(OPIMM, 3'b000, 7'b0000000, 5'd0, 5'd10, 5'd1, 32'h55, 32'h33, 32'd10);
        step();
        chk_out("addi", 1'b1, 32'd0, 32'd10, 4'b0000, 5'd1, 1'b1, 1'b0);

        // ADD x2,x1,x1 : retiring entry beats a stale exm match on x1
        alu_result = 32'd10;
        exm_wen = 1'b1; exm_rd = 5'd1; exm_data = 32'h77;
        drive(OP, 3'b000, 7'b0000000, 5'd1, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0);
        step();
        chk_out("fwd_retire", 1'b1, 32'd10, 32'd10, 4'b0000, 5'd2, 1'b1, 1'b0);

        // SUB x5,x4,x0 : exm beats wb
        alu_result = 32'hDEAD;
        exm_wen = 1'b1; exm_rd = 5'd4; exm_data = 32'hAA;
        wb_wen = 1'b1; wb_rd = 5'd4; wb_data = 32'hBB;
        drive(OP, 3'b000, 7'b0100000, 5'd4, 5'd0, 5'd5, 32'h11, 32'h22, 32'd0);
        step();
        chk_out("fwd_exm", 1'b1, 32'hAA, 32'h0, 4'b0001, 5'd5, 1'b1, 1'b0);

        // OR x7,x4,x4 : wb only
        exm_wen = 1'b0;
        drive(OP, 3'b110, 7'b0000000, 5'd4, 5'd4, 5'd7, 32'h11, 32'h11, 32'd0);
        step();
        chk_out("fwd_wb", 1'b1, 32'hBB, 32'hBB, 4'b0100, 5'd7, 1'b1, 1'b0);
        wb_wen = 1'b0;

        // SLL x6,x1,x2 with x2=0x23 : shift amount masked to 3
        drive(OP, 3'b001, 7'b0000000, 5'd1, 5'd2, 5'd6, 32'd1, 32'h23, 32'd0);
        step();
        chk_out("sll", 1'b1, 32'd1, 32'd3, 4'b1000, 5'd6, 1'b1, 1'b0);

        // SRLI x6,x1,4 with imm=0x24 : masked to 4
        drive(OPIMM, 3'b101, 7'b0000000, 5'd1, 5'd4, 5'd6, 32'h80, 32'h99, 32'h24);
        step();
        chk_out("srli", 1'b1, 32'h80, 32'd4, 4'b0011, 5'd6, 1'b1, 1'b0);

        // ANDI x9,x1,0xF0
        drive(OPIMM, 3'b111, 7'b0000000, 5'd1, 5'd16, 5'd9, 32'hFF, 32'h0, 32'hF0);
        step();
        chk_out("andi", 1'b1, 32'hFF, 32'hF0, 4'b0010, 5'd9, 1'b1, 1'b0);

        // SRAI x10,x1,3 : illegal, still valid, ADD, no writeback
        drive(OPIMM, 3'b101, 7'b0100000, 5'd1, 5'd3, 5'd10, 32'h40, 32'h0, 32'h403);
        step();
        chk("srai.valid",   {31'b0, out_valid},   32'd1);
        chk("srai.illegal", {31'b0, out_illegal}, 32'd1);
        chk("srai.wen",     {31'b0, out_wen},     32'd0);
        chk("srai.ctrl",    {28'b0, alu_ctrl},    32'd0);
        $display("txn srai: valid=%0d ill=%0d wen=%0d", out_valid, out_illegal, out_wen);

        // SLT x11,x1,x2 : illegal register form
        drive(OP, 3'b010, 7'b0000000, 5'd1, 5'd2, 5'd11, 32'd1, 32'd2, 32'd0);
        step();
        chk("slt.illegal", {31'b0, out_illegal}, 32'd1);
        chk("slt.wen",     {31'b0, out_wen},     32'd0);
        $display("txn slt: ill=%0d wen=%0d", out_illegal, out_wen);

        // Load ADD x12 then stall with a SUB pending
        drive(OP, 3'b000, 7'b0000000, 5'd13, 5'd14, 5'd12, 32'd5, 32'd7, 32'd0);
        step();
        chk_out("pre_stall", 1'b1, 32'd5, 32'd7, 4'b0000, 5'd12, 1'b1, 1'b0);
        out_ready = 1'b0;
        drive(OP, 3'b000, 7'b0100000, 5'd13, 5'd14, 5'd13, 32'd9, 32'd3, 32'd0);
        #1;
        chk("stall0.in_ready", {31'b0, in_ready}, 32'd0);
        step();
        chk_out("stall1", 1'b1, 32'd5, 32'd7, 4'b0000, 5'd12, 1'b1, 1'b0);
        chk("stall1.in_ready", {31'b0, in_ready}, 32'd0);
        flush = 1'b1;
        step();
        chk("flush.valid", {31'b0, out_valid}, 32'd0);
        chk("flush.wen",   {31'b0, out_wen},   32'd0);
        chk("flush.rd",    {27'b0, out_rd},    32'd12);
        $display("txn flush: valid=%0d wen=%0d rd=%0d", out_valid, out_wen, out_rd);
        flush = 1'b0;
        #1;
        chk("post_flush.in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk_out("stall3", 1'b1, 32'd9, 32'd3, 4'b0001, 5'd13, 1'b1, 1'b0);

        // Asynchronous reset mid-stall, sampled before the next clock edge
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Fire without a new capture empties the stage
        drive(OP, 3'b111, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'hF0, 32'h3C, 32'd0);
        step();
        chk_out("and", 1'b1, 32'hF0, 32'h3C, 4'b0010, 5'd3, 1'b1, 1'b0);
        in_valid = 1'b0;
        step();
        chk("drain.valid", {31'b0, out_valid}, 32'd0);
        $display("txn drain: valid=%0d", out_valid);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
